// File: rtl/alu_imm_pipe.sv
// Immediate generator, operand muxes and ALU with an iterative shift-add multiplier,
// wrapped in a valid/ready handshake with registered results and result forwarding.
module alu_imm_pipe #(
    parameter int WIDTH     = 16,
    parameter int IMM_WIDTH = 12,
    parameter int SHAMT_W   = $clog2(WIDTH)
) (
    input  logic                 CLK,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    input  logic                 ALUSrcA,
    input  logic                 ALUSrcB,
    input  logic [3:0]           ALUOp,
    input  logic [IMM_WIDTH-1:0] din,
    input  logic [1:0]           numBits,
    input  logic                 immShift,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     ALUOut,
    output logic [WIDTH-1:0]     immGen,
    output logic                 zero,
    output logic                 overflow
);

    localparam int EXT_W = (IMM_WIDTH > WIDTH) ? IMM_WIDTH : WIDTH;
    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        MUL  = 2'd2,
        HOLD = 2'd3
    } aluStateT;

    aluStateT             state_r;
    aluStateT             stateNext_s;

    logic                 inReady_r;
    logic                 outValid_r;
    logic [WIDTH-1:0]     aluOut_r;
    logic [WIDTH-1:0]     immGen_r;
    logic                 zero_r;
    logic                 overflow_r;

    logic [WIDTH-1:0]     opA_r;
    logic [WIDTH-1:0]     opB_r;
    logic [3:0]           op_r;
    logic [WIDTH-1:0]     mulAcc_r;
    logic [CNT_W-1:0]     mulCnt_r;

    logic [EXT_W-1:0]     immField_s;
    logic [WIDTH-1:0]     immExt_s;
    logic [WIDTH-1:0]     opASel_s;
    logic [WIDTH-1:0]     opBSel_s;
    logic [WIDTH-1:0]     aluRes_s;
    logic                 aluOvf_s;
    logic [SHAMT_W-1:0]   shamt_s;
    logic                 accept_s;
    logic                 mulLast_s;

    assign accept_s  = in_valid & inReady_r;
    assign mulLast_s = (mulCnt_r == CNT_W'(WIDTH));
    assign shamt_s   = opB_r[SHAMT_W-1:0];
    assign opASel_s  = ALUSrcA ? aluOut_r : A;
    assign opBSel_s  = ALUSrcB ? immExt_s : B;

    assign in_ready  = inReady_r;
    assign out_valid = outValid_r;
    assign ALUOut    = aluOut_r;
    assign immGen    = immGen_r;
    assign zero      = zero_r;
    assign overflow  = overflow_r;

    // Immediate field select, sign extension and optional halfword-style shift
    always_comb begin
        immField_s = {EXT_W{1'b0}};
        case (numBits)
            2'b00:   immField_s = EXT_W'($signed(din[7:0]));
            2'b01:   immField_s = EXT_W'($signed(din[3:0]));
            2'b10:   immField_s = EXT_W'($signed(din));
            2'b11:   immField_s = EXT_W'($signed(din[5:0]));
            default: immField_s = {EXT_W{1'b0}};
        endcase
        if (immShift) begin
            immExt_s = {immField_s[WIDTH-2:0], 1'b0};
        end else begin
            immExt_s = immField_s[WIDTH-1:0];
        end
    end

    // Single-cycle ALU on the operands captured at acceptance
    always_comb begin
        aluRes_s = {WIDTH{1'b0}};
        aluOvf_s = 1'b0;
        case (op_r)
            4'd0: begin
                aluRes_s = opA_r + opB_r;
                aluOvf_s = (opA_r[WIDTH-1] == opB_r[WIDTH-1]) &&
                           (aluRes_s[WIDTH-1] != opA_r[WIDTH-1]);
            end
            4'd1: begin
                // a - b overflows when a and -b share a sign, i.e. a and b differ
                aluRes_s = opA_r - opB_r;
                aluOvf_s = (opA_r[WIDTH-1] != opB_r[WIDTH-1]) &&
                           (aluRes_s[WIDTH-1] != opA_r[WIDTH-1]);
            end
            4'd2:    aluRes_s = opA_r & opB_r;
            4'd3:    aluRes_s = opA_r | opB_r;
            4'd4:    aluRes_s = opA_r ^ opB_r;
            4'd5:    aluRes_s = opA_r << shamt_s;
            4'd6:    aluRes_s = opA_r >> shamt_s;
            4'd7:    aluRes_s = $signed(opA_r) >>> shamt_s;
            4'd9:    aluRes_s = {{(WIDTH-1){1'b0}}, ($signed(opA_r) < $signed(opB_r))};
            default: aluRes_s = {WIDTH{1'b0}};
        endcase
    end

    // Next-state logic
    always_comb begin
        stateNext_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    stateNext_s = (ALUOp == 4'd8) ? MUL : EXEC;
                end else begin
                    stateNext_s = IDLE;
                end
            end
            EXEC: stateNext_s = HOLD;
            MUL: begin
                if (mulLast_s) begin
                    stateNext_s = HOLD;
                end else begin
                    stateNext_s = MUL;
                end
            end
            HOLD: begin
                // release only once the result has actually been presented
                if (outValid_r && out_ready) begin
                    stateNext_s = IDLE;
                end else begin
                    stateNext_s = HOLD;
                end
            end
            default: stateNext_s = IDLE;
        endcase
    end

    // State register and handshake flags
    always_ff @(posedge CLK) begin
        if (reset) begin
            state_r    <= IDLE;
            inReady_r  <= 1'b0;
            outValid_r <= 1'b0;
        end else begin
            state_r    <= stateNext_s;
            inReady_r  <= (stateNext_s == IDLE);
            outValid_r <= (state_r == HOLD) && (stateNext_s == HOLD);
        end
    end

    // Operand capture, shift-add multiply and result registers
    always_ff @(posedge CLK) begin
        if (reset) begin
            opA_r      <= {WIDTH{1'b0}};
            opB_r      <= {WIDTH{1'b0}};
            op_r       <= 4'd0;
            mulAcc_r   <= {WIDTH{1'b0}};
            mulCnt_r   <= {CNT_W{1'b0}};
            aluOut_r   <= {WIDTH{1'b0}};
            immGen_r   <= {WIDTH{1'b0}};
            zero_r     <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        opA_r    <= opASel_s;
                        opB_r    <= opBSel_s;
                        op_r     <= ALUOp;
                        immGen_r <= immExt_s;
                        mulAcc_r <= {WIDTH{1'b0}};
                        mulCnt_r <= {CNT_W{1'b0}};
                    end else begin
                        opA_r <= opA_r;
                    end
                end
                EXEC: begin
                    aluOut_r   <= aluRes_s;
                    zero_r     <= (aluRes_s == {WIDTH{1'b0}});
                    overflow_r <= aluOvf_s;
                end
                MUL: begin
                    // multiplicand walks left, multiplier walks right, one bit per cycle
                    if (mulLast_s) begin
                        aluOut_r   <= mulAcc_r;
                        zero_r     <= (mulAcc_r == {WIDTH{1'b0}});
                        overflow_r <= 1'b0;
                    end else begin
                        if (opB_r[0]) begin
                            mulAcc_r <= mulAcc_r + opA_r;
                        end else begin
                            mulAcc_r <= mulAcc_r;
                        end
                        opA_r    <= {opA_r[WIDTH-2:0], 1'b0};
                        opB_r    <= {1'b0, opB_r[WIDTH-1:1]};
                        mulCnt_r <= mulCnt_r + CNT_W'(1);
                    end
                end
                HOLD: begin
                    aluOut_r <= aluOut_r;
                end
                default: begin
                    aluOut_r <= aluOut_r;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_imm_pipe.sv
// Directed-vector bench for alu_imm_pipe (WIDTH=16, IMM_WIDTH=12) with hand-computed results.
module tb_alu_imm_pipe;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_SLL = 4'd5;
    localparam logic [3:0] OP_SRL = 4'd6;
    localparam logic [3:0] OP_SRA = 4'd7;
    localparam logic [3:0] OP_MUL = 4'd8;
    localparam logic [3:0] OP_SLT = 4'd9;

    logic        CLK = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] A;
    logic [15:0] B;
    logic        ALUSrcA;
    logic        ALUSrcB;
    logic [3:0]  ALUOp;
    logic [11:0] din;
    logic [1:0]  numBits;
    logic        immShift;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] ALUOut;
    logic [15:0] immGen;
    logic        zero;
    logic        overflow;

    int checkCount = 0;
    int failCount  = 0;

    alu_imm_pipe #(.WIDTH(16), .IMM_WIDTH(12)) dut (
        .CLK(CLK), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .din(din), .numBits(numBits), .immShift(immShift),
        .out_valid(out_valid), .out_ready(out_ready), .ALUOut(ALUOut),
        .immGen(immGen), .zero(zero), .overflow(overflow)
    );

    always #5 CLK = ~CLK;

    task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        if (obs !== exp) begin
            failCount++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one op, check latency and results, optionally stall the consumer, then release.
    task automatic runOp(input string tag,
                         input logic [15:0] a, input logic [15:0] b,
                         input logic srcA, input logic srcB, input logic [3:0] op,
                         input logic [11:0] d, input logic [1:0] nb, input logic sh,
                         input int expLat, input logic [15:0] expOut, input logic [15:0] expImm,
                         input logic expZero, input logic expOvf, input int stallCycles);
        int n;
        int lat;
        n = 0;
        @(negedge CLK);
        while (!in_ready && n < 50) begin
            @(negedge CLK);
            n++;
        end
        checkValue({tag, "_ready"}, {31'd0, in_ready}, 32'd1);
        A = a; B = b; ALUSrcA = srcA; ALUSrcB = srcB; ALUOp = op;
        din = d; numBits = nb; immShift = sh; in_valid = 1'b1;
        @(posedge CLK);
        #1;
        in_valid = 1'b0;
        A = 16'hA5A5; B = 16'h5A5A; din = 12'h9C3; numBits = 2'b10; ALUOp = OP_XOR;
        ALUSrcA = ~srcA; ALUSrcB = ~srcB;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge CLK);
            #1;
            lat++;
        end
        checkValue({tag, "_latency"}, lat, expLat);
        checkValue({tag, "_out"}, {16'd0, ALUOut}, {16'd0, expOut});
        checkValue({tag, "_imm"}, {16'd0, immGen}, {16'd0, expImm});
        checkValue({tag, "_zero"}, {31'd0, zero}, {31'd0, expZero});
        checkValue({tag, "_ovf"}, {31'd0, overflow}, {31'd0, expOvf});
        for (int i = 0; i < stallCycles; i++) begin
            in_valid = 1'b1;
            A = 16'h1111 + 16'(i);
            ALUOp = OP_ADD;
            @(posedge CLK);
            #1;
            in_valid = 1'b0;
            checkValue({tag, "_stall_valid"}, {31'd0, out_valid}, 32'd1);
            checkValue({tag, "_stall_out"}, {16'd0, ALUOut}, {16'd0, expOut});
            checkValue({tag, "_stall_ready"}, {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        @(posedge CLK);
        #1;
        out_ready = 1'b0;
        checkValue({tag, "_rel_valid"}, {31'd0, out_valid}, 32'd0);
        checkValue({tag, "_rel_ready"}, {31'd0, in_ready}, 32'd1);
        checkValue({tag, "_rel_hold"}, {16'd0, ALUOut}, {16'd0, expOut});
    endtask

    task automatic checkCleared(input string tag);
        checkValue({tag, "_ready"}, {31'd0, in_ready}, 32'd0);
        checkValue({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
        checkValue({tag, "_out"}, {16'd0, ALUOut}, 32'd0);
        checkValue({tag, "_imm"}, {16'd0, immGen}, 32'd0);
        checkValue({tag, "_zero"}, {31'd0, zero}, 32'd0);
        checkValue({tag, "_ovf"}, {31'd0, overflow}, 32'd0);
    endtask

    initial begin
        int seen;
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        A = 16'd0; B = 16'd0; ALUSrcA = 1'b0; ALUSrcB = 1'b0; ALUOp = OP_ADD;
        din = 12'd0; numBits = 2'b00; immShift = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        checkCleared("reset");
        reset = 1'b0;
        @(posedge CLK);
        #1;
        checkValue("ready_after_reset", {31'd0, in_ready}, 32'd1);

        //    tag         A        B        sA    sB    op      din      nb     sh    lat out      imm      z     ovf   stall
        runOp("imm4",     16'd2,   16'd0,   1'b0, 1'b1, OP_ADD, 12'd534, 2'b01, 1'b0, 2,  16'd8,   16'd6,   1'b0, 1'b0, 0);
        runOp("regadd",   16'd2,   16'd3,   1'b0, 1'b0, OP_ADD, 12'd0,   2'b00, 1'b0, 2,  16'd5,   16'd0,   1'b0, 1'b0, 0);
        runOp("imm8sh",   16'd0,   16'd7,   1'b0, 1'b1, OP_ADD, 12'h0F8, 2'b00, 1'b1, 2,  16'hFFF0,16'hFFF0,1'b0, 1'b0, 0);
        runOp("imm12sh",  16'd0,   16'd0,   1'b0, 1'b1, OP_ADD, 12'h800, 2'b10, 1'b1, 2,  16'hF000,16'hF000,1'b0, 1'b0, 0);
        runOp("imm6",     16'd1,   16'd0,   1'b0, 1'b1, OP_ADD, 12'h03F, 2'b11, 1'b0, 2,  16'd0,   16'hFFFF,1'b1, 1'b0, 0);
        runOp("addovf",   16'h7FFF,16'd1,   1'b0, 1'b0, OP_ADD, 12'd0,   2'b00, 1'b0, 2,  16'h8000,16'd0,   1'b0, 1'b1, 0);
        runOp("subzero",  16'd5,   16'd5,   1'b0, 1'b0, OP_SUB, 12'd0,   2'b00, 1'b0, 2,  16'd0,   16'd0,   1'b1, 1'b0, 0);
        runOp("subovf",   16'h8000,16'd1,   1'b0, 1'b0, OP_SUB, 12'd0,   2'b00, 1'b0, 2,  16'h7FFF,16'd0,   1'b0, 1'b1, 0);
        runOp("slt",      16'hFFFF,16'd1,   1'b0, 1'b0, OP_SLT, 12'd0,   2'b00, 1'b0, 2,  16'd1,   16'd0,   1'b0, 1'b0, 0);
        runOp("sra",      16'h8000,16'd4,   1'b0, 1'b0, OP_SRA, 12'd0,   2'b00, 1'b0, 2,  16'hF800,16'd0,   1'b0, 1'b0, 0);
        runOp("srl",      16'h8000,16'd4,   1'b0, 1'b0, OP_SRL, 12'd0,   2'b00, 1'b0, 2,  16'h0800,16'd0,   1'b0, 1'b0, 0);
        runOp("sll",      16'd1,   16'h001F,1'b0, 1'b0, OP_SLL, 12'd0,   2'b00, 1'b0, 2,  16'h8000,16'd0,   1'b0, 1'b0, 0);
        runOp("xor",      16'hF0F0,16'h0FF0,1'b0, 1'b0, OP_XOR, 12'd0,   2'b00, 1'b0, 2,  16'hFF00,16'd0,   1'b0, 1'b0, 0);
        runOp("op12",     16'h1234,16'h4321,1'b0, 1'b0, 4'd12,  12'd0,   2'b00, 1'b0, 2,  16'd0,   16'd0,   1'b1, 1'b0, 0);
        runOp("mul",      16'hFFFD,16'd7,   1'b0, 1'b0, OP_MUL, 12'd0,   2'b00, 1'b0, 18, 16'hFFEB,16'd0,   1'b0, 1'b0, 0);
        runOp("fwd",      16'h1234,16'd9,   1'b1, 1'b1, OP_ADD, 12'd1,   2'b01, 1'b0, 2,  16'hFFEC,16'd1,   1'b0, 1'b0, 0);
        runOp("stall",    16'hF0F0,16'h0FF0,1'b0, 1'b0, OP_AND, 12'd0,   2'b00, 1'b0, 2,  16'h00F0,16'd0,   1'b0, 1'b0, 5);

        // stalled in_valid pulses must not have queued a hidden op
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge CLK);
            #1;
            if (out_valid) seen++;
        end
        checkValue("no_queued_op", seen, 0);

        // reset six cycles into a multiply
        @(negedge CLK);
        A = 16'd3; B = 16'd3; ALUSrcA = 1'b0; ALUSrcB = 1'b0; ALUOp = OP_MUL;
        din = 12'd5; numBits = 2'b01; immShift = 1'b0; in_valid = 1'b1;
        @(posedge CLK);
        #1;
        in_valid = 1'b0;
        repeat (6) @(posedge CLK);
        #1;
        checkValue("mul_busy_ready", {31'd0, in_ready}, 32'd0);
        reset = 1'b1;
        @(posedge CLK);
        #1;
        checkCleared("midmul_reset");
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 24; i++) begin
            @(posedge CLK);
            #1;
            if (out_valid) seen++;
        end
        checkValue("midmul_no_output", seen, 0);
        runOp("postreset",16'd1,   16'd1,   1'b0, 1'b0, OP_ADD, 12'd0,   2'b00, 1'b0, 2,  16'd2,   16'd0,   1'b0, 1'b0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
